// File: rtl/ifetch_ctrl_if.sv
// Fetch sequencer bus: redirect input, imem address/response
// and the registered valid/ready beat toward decode.
interface ifetch_ctrl_if;
  logic        redirect_en;
  logic [63:0] redirect_pc;
  logic        out_ready;
  logic [63:0] pc_addr;
  logic [31:0] imem_instr;
  logic        imem_exc_en;
  logic [3:0]  imem_exc_code;
  logic [63:0] imem_exc_val;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic        exc_en;
  logic [3:0]  exc_code;
  logic [63:0] exc_val;
  logic        halted;
  logic [63:0] fetch_cnt;

  modport master (
    input  redirect_en, redirect_pc, out_ready,
    input  imem_instr, imem_exc_en,
    input  imem_exc_code, imem_exc_val,
    output pc_addr, out_valid, out_instr, out_pc,
    output exc_en, exc_code, exc_val,
    output halted, fetch_cnt
  );

  modport slave (
    output redirect_en, redirect_pc, out_ready,
    output imem_instr, imem_exc_en,
    output imem_exc_code, imem_exc_val,
    input  pc_addr, out_valid, out_instr, out_pc,
    input  exc_en, exc_code, exc_val,
    input  halted, fetch_cnt
  );
endinterface

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, registers imem
// output into a decode beat, halts after an exception beat.
module ifetch_ctrl #(
  parameter logic [63:0] RESET_VEC = 64'h0,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic          clk,
  input  logic          rst,
  ifetch_ctrl_if.master bus
);

  typedef enum logic {RUN, HALT} state_t;

  state_t      state, state_nxt;
  logic [63:0] pc;
  logic        valid;
  logic [31:0] instr;
  logic [63:0] opc;
  logic        exc;
  logic [3:0]  code;
  logic [63:0] val;
  logic [63:0] cnt;
  logic        load;
  logic        misal;
  logic        fault;
  logic        accept;

  assign misal  = pc[1:0] != 2'b00;
  assign fault  = misal || bus.imem_exc_en;
  assign accept = valid && bus.out_ready;
  assign load   = (state == RUN) && !bus.redirect_en
                  && (!valid || bus.out_ready);

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // redirect always resumes; a faulting load halts
  always_comb begin
    state_nxt = state;
    if (bus.redirect_en)    state_nxt = RUN;
    else if (load && fault) state_nxt = HALT;
  end

  // fetch PC, output beat and accepted-beat counter
  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= RESET_VEC;
      valid <= 1'b0;
      instr <= NOP_INSTR;
      opc   <= 64'h0;
      exc   <= 1'b0;
      code  <= 4'h0;
      val   <= 64'h0;
      cnt   <= 64'h0;
    end else begin
      if (accept && !exc) cnt <= cnt + 64'd1;
      if (bus.redirect_en) begin
        pc    <= bus.redirect_pc;
        valid <= 1'b0;
      end else if (load) begin
        valid <= 1'b1;
        opc   <= pc;
        unique case (1'b1)
          misal: begin
            instr <= NOP_INSTR;
            exc   <= 1'b1;
            code  <= 4'h0;
            val   <= pc;
          end
          bus.imem_exc_en: begin
            instr <= NOP_INSTR;
            exc   <= 1'b1;
            code  <= bus.imem_exc_code;
            val   <= bus.imem_exc_val;
          end
          default: begin
            instr <= bus.imem_instr;
            exc   <= 1'b0;
            code  <= 4'h0;
            val   <= 64'h0;
            pc    <= pc + 64'd4;
          end
        endcase
      end else if (accept) begin
        valid <= 1'b0;
      end
    end
  end

  assign bus.pc_addr   = pc;
  assign bus.out_valid = valid;
  assign bus.out_instr = instr;
  assign bus.out_pc    = opc;
  assign bus.exc_en    = exc;
  assign bus.exc_code  = code;
  assign bus.exc_val   = val;
  assign bus.halted    = state == HALT;
  assign bus.fetch_cnt = cnt;

endmodule
